// File: rtl/ascii_save.sv
// ascii_save: captures CPU serial TX bytes into a RAM buffer and serves them to the HPS as a save-file upload.
module ascii_save #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              tx_strobe,
  input  logic [7:0]        tx_data,
  input  logic              capture_en,
  input  logic              ioctl_upload,
  input  logic              ioctl_rd,
  input  logic [15:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic [ADDR_W:0]   save_len,
  output logic              overflow,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, CAPTURE, UPLOAD} state_t;
  state_t state, nxt;
  logic [7:0] mem [2**ADDR_W];
  logic [7:0] rd_q;
  logic [16:0] len_x;
  logic hit, start, full, we, re, in_range;
  always_comb begin
    nxt = ioctl_upload ? UPLOAD :
          (state == UPLOAD) ? IDLE :
          (state == IDLE && capture_en) ? CAPTURE :
          (state == CAPTURE && !capture_en) ? IDLE : state;
    start = state == IDLE && nxt == CAPTURE;
    full = save_len[ADDR_W];
    we = state == CAPTURE && tx_strobe && !full;
    re = state == UPLOAD && ioctl_rd;
    len_x = 17'(save_len);
    in_range = {1'b0, ioctl_addr} < len_x;
  end
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state <= IDLE;
      busy <= 1'b0;
      save_len <= '0;
      overflow <= 1'b0;
      hit <= 1'b0;
    end else begin
      state <= nxt;
      busy <= nxt != IDLE;
      if (start) begin
        save_len <= '0;
        overflow <= 1'b0;
      end else if (we) save_len <= save_len + (ADDR_W+1)'(1);
      else if (state == CAPTURE && tx_strobe) overflow <= 1'b1;
      if (re) hit <= in_range;
    end
  end
  // RAM is never reset; the hit flag masks stale or out-of-range data to zero.
  always_ff @(posedge clk) begin
    if (we) mem[save_len[ADDR_W-1:0]] <= tx_data;
    if (re) rd_q <= mem[ioctl_addr[ADDR_W-1:0]];
  end
  assign ioctl_din = hit ? rd_q : 8'h00;
endmodule

// File: tb/tb_ascii_save.sv
// tb_ascii_save: directed self-checking bench for ascii_save with a 16-byte buffer.
module tb_ascii_save;
  localparam int ADDR_W = 4;
  logic clk = 1'b0, n_reset = 1'b0, tx_strobe = 1'b0, capture_en = 1'b0;
  logic ioctl_upload = 1'b0, ioctl_rd = 1'b0, overflow, busy;
  logic [7:0] tx_data = 8'h00, ioctl_din;
  logic [15:0] ioctl_addr = 16'h0000;
  logic [ADDR_W:0] save_len;
  int n_tests = 0, n_fail = 0;
  ascii_save #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .n_reset(n_reset), .tx_strobe(tx_strobe), .tx_data(tx_data),
    .capture_en(capture_en), .ioctl_upload(ioctl_upload), .ioctl_rd(ioctl_rd),
    .ioctl_addr(ioctl_addr), .ioctl_din(ioctl_din), .save_len(save_len),
    .overflow(overflow), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic strobe(input logic [7:0] b);
    tx_data = b;
    tx_strobe = 1'b1;
    @(negedge clk);
    tx_strobe = 1'b0;
  endtask
  task automatic rd(input string tag, input logic [15:0] a, input logic [7:0] exp);
    ioctl_addr = a;
    ioctl_rd = 1'b1;
    @(negedge clk);
    ioctl_rd = 1'b0;
    chk(tag, 16'(ioctl_din), 16'(exp));
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_len", 16'(save_len), 16'd0);
    chk("rst_ovf", 16'(overflow), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_din", 16'(ioctl_din), 16'h00);
    n_reset = 1'b1;
    @(negedge clk);
    chk("idle_busy", 16'(busy), 16'd0);
    // basic capture and read-back
    capture_en = 1'b1;
    @(negedge clk);
    chk("cap_busy", 16'(busy), 16'd1);
    strobe(8'h48);
    strobe(8'h49);
    strobe(8'h0D);
    capture_en = 1'b0;
    @(negedge clk);
    chk("basic_len", 16'(save_len), 16'd3);
    chk("basic_idle", 16'(busy), 16'd0);
    ioctl_upload = 1'b1;
    @(negedge clk);
    chk("up_busy", 16'(busy), 16'd1);
    rd("rd0", 16'd0, 8'h48);
    rd("rd1", 16'd1, 8'h49);
    rd("rd2", 16'd2, 8'h0D);
    rd("rd3", 16'd3, 8'h00);
    rd("rd4", 16'd4, 8'h00);
    rd("rd_alias", 16'h0010, 8'h00);
    rd("rd_high", 16'h0100, 8'h00);
    rd("rd1b", 16'd1, 8'h49);
    repeat (2) @(negedge clk);
    chk("din_hold", 16'(ioctl_din), 16'h49);
    ioctl_upload = 1'b0;
    @(negedge clk);
    ioctl_addr = 16'd0;
    ioctl_rd = 1'b1;
    @(negedge clk);
    ioctl_rd = 1'b0;
    chk("rd_idle_ign", 16'(ioctl_din), 16'h49);
    strobe(8'h77);
    chk("strb_idle_ign", 16'(save_len), 16'd3);
    // full buffer: 17 strobes into 16 bytes
    capture_en = 1'b1;
    @(negedge clk);
    chk("fill_clear", 16'(save_len), 16'd0);
    for (int i = 0; i < 17; i++) strobe(8'(8'h10 + i));
    chk("full_len", 16'(save_len), 16'd16);
    chk("full_ovf", 16'(overflow), 16'd1);
    capture_en = 1'b0;
    ioctl_upload = 1'b1;
    repeat (2) @(negedge clk);
    rd("full_rd15", 16'd15, 8'h1F);
    rd("full_rd0", 16'd0, 8'h10);
    rd("full_rd16", 16'd16, 8'h00);
    ioctl_upload = 1'b0;
    @(negedge clk);
    chk("ovf_retain", 16'(overflow), 16'd1);
    chk("len_retain", 16'(save_len), 16'd16);
    // recapture clears, strobe in the transition cycle is ignored
    tx_data = 8'hAA;
    tx_strobe = 1'b1;
    capture_en = 1'b1;
    @(negedge clk);
    tx_strobe = 1'b0;
    chk("recap_len0", 16'(save_len), 16'd0);
    chk("recap_ovf0", 16'(overflow), 16'd0);
    for (int i = 0; i < 5; i++) strobe(8'(8'h31 + i));
    chk("five_len", 16'(save_len), 16'd5);
    capture_en = 1'b0;
    @(negedge clk);
    tx_data = 8'hEE;
    tx_strobe = 1'b1;
    capture_en = 1'b1;
    @(negedge clk);
    tx_strobe = 1'b0;
    chk("recap2_len0", 16'(save_len), 16'd0);
    strobe(8'h5A);
    chk("recap2_len1", 16'(save_len), 16'd1);
    capture_en = 1'b0;
    ioctl_upload = 1'b1;
    repeat (2) @(negedge clk);
    rd("recap_rd0", 16'd0, 8'h5A);
    rd("recap_rd1", 16'd1, 8'h00);
    ioctl_upload = 1'b0;
    @(negedge clk);
    // upload preempts capture
    capture_en = 1'b1;
    @(negedge clk);
    strobe(8'h11);
    strobe(8'h22);
    chk("pre_len", 16'(save_len), 16'd2);
    ioctl_upload = 1'b1;
    @(negedge clk);
    strobe(8'h55);
    chk("pre_len_kept", 16'(save_len), 16'd2);
    rd("pre_rd2", 16'd2, 8'h00);
    rd("pre_rd0", 16'd0, 8'h11);
    rd("pre_rd1", 16'd1, 8'h22);
    ioctl_upload = 1'b0;
    @(negedge clk);
    chk("pre_idle", 16'(busy), 16'd0);
    chk("pre_idle_len", 16'(save_len), 16'd2);
    @(negedge clk);
    chk("pre_cap", 16'(busy), 16'd1);
    chk("pre_cap_len", 16'(save_len), 16'd0);
    // asynchronous reset mid-capture
    strobe(8'h61);
    strobe(8'h62);
    strobe(8'h63);
    chk("mid_len", 16'(save_len), 16'd3);
    #2 n_reset = 1'b0;
    capture_en = 1'b0;
    #1;
    chk("arst_len", 16'(save_len), 16'd0);
    chk("arst_busy", 16'(busy), 16'd0);
    chk("arst_din", 16'(ioctl_din), 16'h00);
    @(negedge clk);
    n_reset = 1'b1;
    @(negedge clk);
    chk("post_idle", 16'(busy), 16'd0);
    ioctl_upload = 1'b1;
    @(negedge clk);
    rd("post_rd0", 16'd0, 8'h00);
    ioctl_upload = 1'b0;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ascii_save.md
ASCII_SAVE -- requirements
Module: ascii_save

Interface
- REQ-001 SHALL have parameter ADDR_W, default 12, log2 of buffer depth (4096 bytes).
- REQ-002 SHALL have port clk, input, 1, system clock (48 MHz clk_sys domain).
- REQ-003 SHALL have port n_reset, input, 1, reset, asynchronous, active-low.
- REQ-004 SHALL have port tx_strobe, input, 1, one-cycle pulse when the CPU writes the ACIA transmit register.
- REQ-005 SHALL have port tx_data, input, 8, byte written; valid only while tx_strobe=1.
- REQ-006 SHALL have port capture_en, input, 1, OSD "save to file" enable, level.
- REQ-007 SHALL have port ioctl_upload, input, 1, HPS upload session active, level.
- REQ-008 SHALL have port ioctl_rd, input, 1, HPS read request pulse, one cycle.
- REQ-009 SHALL have port ioctl_addr, input, 16, HPS byte address of the read.
- REQ-010 SHALL have port ioctl_din, output, 8, read data returned to the HPS.
- REQ-011 SHALL have port save_len, output, ADDR_W+1, bytes captured in the current buffer.
- REQ-012 SHALL have port overflow, output, 1, sticky flag: at least one byte was dropped because the buffer was full.
- REQ-013 SHALL have port busy, output, 1, high in CAPTURE or UPLOAD.

Function
- REQ-014 SHALL implement 2^ADDR_W x 8 single-clock RAM: one write port and one read port with 1-cycle registered read.
- REQ-015 SHALL implement three states, IDLE, CAPTURE and UPLOAD, in a registered state machine.
- REQ-016 SHALL evaluate state transitions in the following priority:
  - ioctl_upload=1 in any state -> UPLOAD.
  - UPLOAD with ioctl_upload=0 -> IDLE.
  - IDLE with capture_en=1 -> CAPTURE.
  - CAPTURE with capture_en=0 -> IDLE.
- REQ-017 SHALL, on the IDLE->CAPTURE transition cycle, clear save_len to 0 and clear overflow; a tx_strobe in that same cycle SHALL be ignored.
- REQ-018 SHALL, in CAPTURE with tx_strobe=1 and save_len<2^ADDR_W, write tx_data at RAM[save_len] and increment save_len by 1 on the next edge.
- REQ-019 SHALL, in CAPTURE with tx_strobe=1 and save_len=2^ADDR_W, leave RAM and save_len unchanged and set overflow=1.
- REQ-020 SHALL ignore tx_strobe in IDLE and in UPLOAD.
- REQ-021 SHALL, when leaving CAPTURE, retain save_len and RAM contents until the next IDLE->CAPTURE transition.
- REQ-022 SHALL, in UPLOAD on ioctl_rd=1, drive ioctl_din from the edge one cycle later and hold it until the next ioctl_rd:
  - RAM[ioctl_addr] when ioctl_addr<save_len.
  - 8'h00 when ioctl_addr>=save_len, including any address with bits above ADDR_W set.
- REQ-023 SHALL treat consecutive-cycle ioctl_rd pulses as independent, each with 1-cycle latency (full throughput).
- REQ-024 SHALL ignore ioctl_rd outside UPLOAD and leave ioctl_din unchanged.
- REQ-025 SHALL keep an upload that interrupts CAPTURE non-destructive: save_len and RAM are kept; after UPLOAD ends with capture_en=1, the path is UPLOAD->IDLE->CAPTURE, which clears the buffer per REQ-017.
- REQ-026 SHALL drive busy=1 exactly when state is CAPTURE or UPLOAD.
- REQ-027 SHALL keep save_len saturated at 2^ADDR_W and never wrap.

Reset
- REQ-028 SHALL, on n_reset=0, immediately and asynchronously force: state=IDLE, save_len=0, overflow=0, ioctl_din=8'h00, busy=0.
- REQ-029 SHALL not require RAM contents to be cleared by reset; save_len=0 makes all reads return 8'h00.
- REQ-030 SHALL, when reset asserts mid-CAPTURE or mid-UPLOAD, abort the operation; after release the block stays in IDLE until capture_en or ioctl_upload is sampled high.

Verification
- REQ-031 Basic capture and read-back:
  - Stimulus: capture_en=1; strobe 0x48, 0x49, 0x0D; capture_en=0; upload and read addresses 0..4.
  - Required: save_len=3; ioctl_din = 0x48, 0x49, 0x0D, 0x00, 0x00, each 1 cycle after its ioctl_rd.
- REQ-032 Full buffer (ADDR_W=4):
  - Stimulus: 17 strobes.
  - Required: save_len=16, overflow=1, RAM[15]=16th byte, 17th byte absent.
- REQ-033 Recapture clears the buffer:
  - Stimulus: capture 5 bytes, drop capture_en, raise it again with a tx_strobe in the transition cycle.
  - Required: save_len=0, overflow=0; next strobe lands at address 0.
- REQ-034 Upload preempts capture:
  - Stimulus: ioctl_upload=1 while in CAPTURE with save_len=2; strobe 0x55.
  - Required: save_len stays 2; reads return the original 2 bytes; after upload ends the block passes IDLE then CAPTURE with save_len=0.
- REQ-035 Reset mid-capture:
  - Stimulus: n_reset low for 1 cycle after 3 captured bytes.
  - Required: immediately save_len=0, busy=0, ioctl_din=0x00; a read at address 0 during a later upload returns 0x00.
